// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multi-cycle control unit.
// Holds the FSM states, RV32I opcode constants, alu_control codes,
// pc_src / wb_sel mux codes and the supported-opcode check.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JAL    = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    function automatic logic opcode_ok(input logic [6:0] op);
        return op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL};
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps opcode/funct3/funct7_b5 to alu_control plus a funct-illegal flag.
// Ports: opcode[6:0], funct3[2:0], funct7_b5 in; alu_control[2:0], funct_illegal out.
// Purely combinational. Loads/stores get ADD (address), branches get SUB (compare).
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    output logic [2:0] alu_control,
    output logic       funct_illegal
);

    logic       is_alu;
    logic [2:0] f_op;

    assign is_alu = (opcode == OP_R) || (opcode == OP_I);

    always_comb begin
        case (funct3)
            3'b000:  f_op = (opcode == OP_R && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'b111:  f_op = ALU_AND;
            3'b110:  f_op = ALU_OR;
            3'b100:  f_op = ALU_XOR;
            3'b010:  f_op = ALU_SLT;
            3'b001:  f_op = ALU_SLL;
            3'b101:  f_op = ALU_SRL;
            default: f_op = ALU_ADD;
        endcase
    end

    assign alu_control   = is_alu ? f_op : (opcode == OP_BRANCH) ? ALU_SUB : ALU_ADD;
    assign funct_illegal = (is_alu && funct3 == 3'b011) ||
                           (opcode == OP_BRANCH && funct3 != 3'b000);

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer driving the shared RV32I datapath.
// Inputs : clk, reset (async, active-low), opcode[6:0], funct3[2:0], funct7_b5,
//          zero (ALU flag), mem_ready (completes current imem/dmem request).
// Outputs: imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src[1:0], reg_we,
//          wb_sel[1:0], alu_src_b, alu_control[2:0], illegal, instr_done.
// Optional: define CTRL_PERF_EN to add cycle_cnt[31:0] and instret_cnt[31:0].
// Outputs are decoded from the state register and gated by reset, so a
// pending memory request drops in the same cycle reset is asserted.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       reg_we,
    output logic [1:0] wb_sel,
    output logic       alu_src_b,
    output logic [2:0] alu_control,
    output logic       illegal,
    output logic       instr_done
`ifdef CTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    state_t     state;
    logic [2:0] dec_alu;
    logic       funct_illegal;
    logic       is_i, is_load, is_store, is_branch, is_jal;
    logic       in_exec;

    alu_decoder u_alu_decoder (
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7_b5     (funct7_b5),
        .alu_control   (dec_alu),
        .funct_illegal (funct_illegal)
    );

    assign is_i      = opcode == OP_I;
    assign is_load   = opcode == OP_LOAD;
    assign is_store  = opcode == OP_STORE;
    assign is_branch = opcode == OP_BRANCH;
    assign is_jal    = opcode == OP_JAL;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:  state <= mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: state <= (opcode_ok(opcode) && !funct_illegal) ? S_EXEC : S_TRAP;
                S_EXEC:   state <= (is_load || is_store) ? S_MEM : is_branch ? S_FETCH : S_WB;
                S_MEM:    state <= !mem_ready ? S_MEM : is_load ? S_WB : S_FETCH;
                S_WB:     state <= S_FETCH;
                default:  state <= S_TRAP;
            endcase
        end
    end

    assign in_exec     = reset && state == S_EXEC;
    assign imem_req    = reset && state == S_FETCH;
    assign ir_we       = imem_req && mem_ready;
    assign dmem_req    = reset && state == S_MEM;
    assign dmem_we     = dmem_req && is_store;
    assign pc_we       = ir_we || (in_exec && (is_jal || (is_branch && zero)));
    assign pc_src      = (in_exec && is_branch) ? PC_BRANCH : (in_exec && is_jal) ? PC_JAL : PC_PLUS4;
    assign reg_we      = reset && state == S_WB;
    assign wb_sel      = !reg_we ? WB_ALU : is_load ? WB_MEM : is_jal ? WB_PC4 : WB_ALU;
    assign alu_src_b   = in_exec && (is_i || is_load || is_store);
    assign alu_control = in_exec ? dec_alu : ALU_ADD;
    // TRAP is absorbing, so tying illegal to the state makes it sticky until reset.
    assign illegal     = reset && state == S_TRAP;
    assign instr_done  = reg_we || (in_exec && is_branch) || (dmem_we && mem_ready);

`ifdef CTRL_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (state != S_TRAP) cycle_cnt <= cycle_cnt + 32'd1;
            if (instr_done) instret_cnt <= instret_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control unit for the RV32I-subset processor core. It sequences each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives every enable and mux select of the shared datapath: PC, instruction register, register file, ALU and data memory. It stalls on a single memory-ready handshake, so instruction and data memories can have wait states. It sits between the datapath and the memories and replaces the single-cycle decode.

## Interface
- No parameters. Widths are fixed by the core: 7-bit opcode, 3-bit `alu_control`.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low. 0 = reset.
- `opcode`  in  7  instruction register bits [6:0].
- `funct3`  in  3  instruction register bits [14:12].
- `funct7_b5`  in  1  instruction register bit 30.
- `zero`  in  1  ALU zero flag, valid in EXEC.
- `mem_ready`  in  1  memory completion for the current `imem_req`/`dmem_req`.
- `imem_req`  out  1  instruction fetch request.
- `dmem_req`  out  1  data memory request.
- `dmem_we`  out  1  data memory write (store).
- `ir_we`  out  1  instruction register and old-PC capture.
- `pc_we`  out  1  PC write.
- `pc_src`  out  2  0 = PC+4, 1 = branch target (old_pc+imm), 2 = JAL target.
- `reg_we`  out  1  register file write.
- `wb_sel`  out  2  0 = ALU result, 1 = memory read data, 2 = old_pc+4.
- `alu_src_b`  out  1  0 = rs2, 1 = immediate.
- `alu_control`  out  3  ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLT 101, SLL 110, SRL 111.
- `illegal`  out  1  sticky; unsupported opcode was decoded.
- `instr_done`  out  1  one-cycle pulse in the last cycle of each instruction.

## Operation
- Supported opcodes:
  - R 0110011
  - I-ALU 0010011
  - LOAD 0000011
  - STORE 0100011
  - BRANCH 1100011 (BEQ only, funct3=000)
  - JAL 1101111
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Outputs are combinational from the state register plus `opcode`/`funct3`/`zero`. Every output not listed for a state is 0.
- FETCH:
  - `imem_req`=1 while waiting.
  - When `mem_ready`=1: `ir_we`=1, `pc_we`=1, `pc_src`=0, then go to DECODE. Otherwise stay.
- DECODE (always 1 cycle):
  - Supported opcode: go to EXEC.
  - Unsupported opcode, or BRANCH with funct3≠000: go to TRAP and set `illegal`.
- EXEC:
  - `alu_control` comes from the decoder.
  - `alu_src_b`=1 for I-ALU, LOAD and STORE.
  - R and I-ALU: go to WB.
  - LOAD and STORE: `alu_control`=ADD, go to MEM.
  - BRANCH: `alu_control`=SUB, `pc_we`=`zero`, `pc_src`=1, `instr_done`=1, go to FETCH.
  - JAL: `pc_we`=1, `pc_src`=2, go to WB.
- MEM:
  - `dmem_req`=1; `dmem_we`=1 for STORE.
  - Hold until `mem_ready`.
  - STORE: `instr_done`=1 on the ready cycle, go to FETCH.
  - LOAD: go to WB.
- WB:
  - `reg_we`=1.
  - `wb_sel`=1 for LOAD, 2 for JAL, otherwise 0.
  - `instr_done`=1, go to FETCH.
- TRAP: absorbing state, no requests issued. `illegal` stays 1 until reset.
- ALU decode:
  - R: funct3 000 gives ADD, or SUB when `funct7_b5`=1. 111 AND, 110 OR, 100 XOR, 010 SLT, 001 SLL, 101 SRL.
  - I-ALU: same mapping, except `funct7_b5` is ignored for funct3=000 (always ADD).
  - Any other funct3 is illegal and goes to TRAP.

## Timing
- Reset:
  - While `reset`=0, state=FETCH and all outputs are forced to 0.
  - The first `imem_req` is in the first cycle after `reset` deasserts.
  - Reset asserted mid-instruction aborts it immediately. A pending memory request drops the same cycle.
- Minimum cycles (zero-wait memory): R / I-ALU / JAL 4, LOAD 5, STORE 4, BRANCH 3. Each wait cycle adds 1.
- A request stays asserted with stable `dmem_we` until the cycle `mem_ready`=1 is sampled. `mem_ready` is ignored when no request is asserted.
- `opcode`/`funct3` must stay stable from DECODE until `instr_done`. The IR is only written in FETCH.

## Configuration
- `CTRL_PERF_EN` defined:
  - Adds output `cycle_cnt` [31:0], incremented every cycle out of reset except in TRAP.
  - Adds output `instret_cnt` [31:0], incremented on each `instr_done`.
  - Both clear to 0 on reset and wrap modulo 2^32.
- `CTRL_PERF_EN` undefined: neither port nor counter exists.

## Structure
- `ctrl_pkg`: state encoding, opcode constants, `alu_control` codes, `pc_src` and `wb_sel` codes.
- Sub-module `alu_decoder`: combinational, maps `opcode`/`funct3`/`funct7_b5` to `alu_control` plus a funct-illegal flag. The FSM instantiates it once.

## Test plan
- Reset release, `mem_ready` tied 1, IR=0x002081B3 (add x3,x1,x2) -> states FETCH, DECODE, EXEC, WB. `reg_we`=1 and `wb_sel`=0 in cycle 4. `instr_done` in cycle 4.
- LOAD 0x0000A183 with `mem_ready` low for 3 cycles in MEM -> `dmem_req` held 4 cycles with `dmem_we`=0, then WB with `wb_sel`=1. Total 8 cycles.
- BEQ with `zero`=1 -> `pc_we`=1 and `pc_src`=1 in cycle 3. Repeat with `zero`=0 -> `pc_we`=0, next FETCH in cycle 4.
- JAL 0x0000006F -> EXEC `pc_src`=2 with `pc_we`=1; WB `wb_sel`=2 with `reg_we`=1.
- Opcode 0x7F -> TRAP after DECODE, `illegal`=1. No further `imem_req` until `reset` pulses low, after which `illegal`=0.
- `reset` driven low during MEM of a STORE -> `dmem_req`/`dmem_we` drop within the same cycle. With `CTRL_PERF_EN`, `cycle_cnt` and `instret_cnt` read 0.
